// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_DONE = 3'd2,
      ABORT     = 3'd3,
      GUARD     = 3'd4
   } sched_state_t;

   localparam int UART_WORD_W = 9;
   localparam int SCHED_CNT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   grant,
   output logic [IDW-1:0] grant_idx
);

   logic [IDW:0] cand;
   logic         found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int k = 0; k < N; k++) begin
         // One spare bit keeps ptr+k exact before folding back into range
         cand = {1'b0, ptr} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(N)) cand = cand - (IDW+1)'(N);
         if (!found && req[cand[IDW-1:0]]) begin
            found     = 1'b1;
            grant_idx = cand[IDW-1:0];
         end
      end
      grant[grant_idx] = found;
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ requesters with round-robin grants,
// start/frame watchdogs, a post-frame guard gap and per-frame status.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int START_TIMEOUT = 16,
   parameter int FRAME_TIMEOUT = 65535,
   parameter int GUARD_CYCLES  = 2,
   parameter int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*UART_WORD_W-1:0] req_data,
   output logic [NUM_REQ-1:0]             gnt,
   output logic                           uart_start,
   output logic [UART_WORD_W-1:0]         uart_data,
   input  logic                           uart_ready,
   input  logic                           uart_busy,
   input  logic                           uart_error,
   output logic                           frame_done,
   output logic [IDW-1:0]                 frame_src,
   output logic                           frame_err,
   output logic                           frame_timeout,
   output logic                           sched_busy
);

   localparam logic [SCHED_CNT_W-1:0] START_LIM = SCHED_CNT_W'(START_TIMEOUT - 1);
   localparam logic [SCHED_CNT_W-1:0] FRAME_LIM = SCHED_CNT_W'(FRAME_TIMEOUT - 1);
   localparam logic [SCHED_CNT_W-1:0] GUARD_LIM =
      (GUARD_CYCLES > 0) ? SCHED_CNT_W'(GUARD_CYCLES - 1) : '0;
   localparam sched_state_t POST_ST = (GUARD_CYCLES == 0) ? IDLE : GUARD;

   sched_state_t               state_q, state_d;
   logic [SCHED_CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
   logic [IDW-1:0]             ptr_q, ptr_d, ptr_next;
   logic [IDW-1:0]             src_q, src_d;
   logic [UART_WORD_W-1:0]     data_q, data_d;
   logic                       start_q, start_d;
   logic                       done_q, done_d;
   logic                       err_q, err_d;
   logic                       to_q, to_d;

   logic [NUM_REQ-1:0]         arb_grant;
   logic [IDW-1:0]             arb_idx;
   logic                       grant_ok;
   logic [UART_WORD_W-1:0]     words [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_word
      assign words[i] = req_data[i*UART_WORD_W +: UART_WORD_W];
   end

   rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_arb (
      .req       (req),
      .ptr       (ptr_q),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   // rst_n gates the grant so gnt is 0 while reset is held, even though state_q reads IDLE
   assign grant_ok = rst_n && (state_q == IDLE) && uart_ready && (req != '0);
   assign gnt      = grant_ok ? arb_grant : '0;
   assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + SCHED_CNT_W'(1);
   assign ptr_next = (src_q == IDW'(NUM_REQ - 1)) ? '0 : src_q + IDW'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      src_d   = src_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      to_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (grant_ok) begin
               data_d  = words[arb_idx];
               src_d   = arb_idx;
               cnt_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (uart_busy) begin
               cnt_d   = '0;
               state_d = WAIT_DONE;
            end else if (cnt_q >= START_LIM) begin
               done_d  = 1'b1;
               to_d    = 1'b1;
               ptr_d   = ptr_next;
               state_d = ABORT;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         WAIT_DONE: begin
            if (!uart_busy && uart_ready) begin
               done_d  = 1'b1;
               err_d   = uart_error;
               ptr_d   = ptr_next;
               cnt_d   = '0;
               state_d = POST_ST;
            end else if (cnt_q >= FRAME_LIM) begin
               done_d  = 1'b1;
               to_d    = 1'b1;
               ptr_d   = ptr_next;
               state_d = ABORT;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ABORT: begin
            cnt_d   = '0;
            state_d = POST_ST;
         end
         GUARD: begin
            if (cnt_q >= GUARD_LIM) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = IDLE;
      endcase
      start_d = (state_d == ISSUE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         src_q   <= '0;
         data_q  <= '0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         src_q   <= src_d;
         data_q  <= data_d;
         start_q <= start_d;
         done_q  <= done_d;
         err_q   <= err_d;
         to_q    <= to_d;
      end
   end

   assign uart_start    = start_q;
   assign uart_data     = data_q;
   assign frame_done    = done_q;
   assign frame_src     = src_q;
   assign frame_err     = err_q;
   assign frame_timeout = to_q;
   assign sched_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: vector table, directed corner sequences and a
// randomized run checked against a round-robin scoreboard with a simple driver model.
module tb_uart_tx_scheduler;

   localparam int NR    = 4;
   localparam int GUARD = 2;
   localparam int STO   = 16;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req   = 4'b1111;
   logic [35:0] req_data = '0;
   logic [3:0]  gnt;
   logic        uart_start;
   logic [8:0]  uart_data;
   logic        uart_ready;
   logic        uart_busy  = 1'b0;
   logic        uart_error = 1'b0;
   logic        drv_ready  = 1'b1;
   logic        ready_en   = 1'b1;
   logic        frame_done;
   logic [1:0]  frame_src;
   logic        frame_err;
   logic        frame_timeout;
   logic        sched_busy;

   int drv_lat = 1, drv_len = 3;
   bit drv_err = 0, drv_never = 0;
   int dphase = 0, dcnt = 0;
   int n_cmp = 0, n_fail = 0;

   assign uart_ready = drv_ready & ready_en;

   uart_tx_scheduler #(
      .NUM_REQ(NR), .START_TIMEOUT(STO), .FRAME_TIMEOUT(65535), .GUARD_CYCLES(GUARD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
      .uart_start(uart_start), .uart_data(uart_data), .uart_ready(uart_ready),
      .uart_busy(uart_busy), .uart_error(uart_error), .frame_done(frame_done),
      .frame_src(frame_src), .frame_err(frame_err), .frame_timeout(frame_timeout),
      .sched_busy(sched_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Driver model: busy rises drv_lat cycles after start, lasts drv_len cycles,
   // then ready returns with uart_error = drv_err. drv_never: never goes busy.
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         dphase = 0; uart_busy = 1'b0; drv_ready = 1'b1; uart_error = 1'b0;
      end else begin
         case (dphase)
            0: if (uart_start) begin
                  uart_error = 1'b0; dcnt = 0; dphase = drv_never ? 3 : 1;
               end
            1: begin
                  dcnt++;
                  if (dcnt >= drv_lat) begin uart_busy = 1'b1; drv_ready = 1'b0; dcnt = 0; dphase = 2; end
               end
            2: begin
                  dcnt++;
                  if (dcnt >= drv_len) begin uart_busy = 1'b0; drv_ready = 1'b1; uart_error = drv_err; dphase = 0; end
               end
            default: if (!uart_start) dphase = 0;
         endcase
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] r, input int p);
      int j;
      for (int k = 0; k < NR; k++) begin
         j = (p + k) % NR;
         if (r[j[1:0]]) return j;
      end
      return -1;
   endfunction

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; req = '0; ready_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_idle(input string nm);
      int k = 0;
      do begin @(negedge clk); k++; end while (sched_busy && k < 300);
      chk({nm, " idle"}, sched_busy, 0);
   endtask

   task automatic run_frame(input string nm, input logic [3:0] mask, input logic [8:0] data,
                            input int idx, input int lat, input int len, input bit err, input bit never);
      int k;
      drv_lat = lat; drv_len = len; drv_err = err; drv_never = never;
      @(posedge clk); #1;
      req = mask;
      for (int i = 0; i < NR; i++) req_data[i*9 +: 9] = 9'($urandom);
      req_data[idx*9 +: 9] = data;
      k = 0;
      do begin @(negedge clk); k++; end while (gnt == '0 && k < 100);
      chk({nm, " gnt"}, gnt, 1 << idx);
      @(posedge clk); #1 req = '0;
      @(negedge clk);
      chk({nm, " data"}, uart_data, data);
      chk({nm, " start"}, uart_start, 1);
      k = 0;
      do begin @(negedge clk); k++; end while (!frame_done && k < 400);
      chk({nm, " done"}, frame_done, 1);
      chk({nm, " src"}, frame_src, idx);
      chk({nm, " err"}, frame_err, err && !never);
      chk({nm, " timeout"}, frame_timeout, never);
      chk({nm, " data_hold"}, uart_data, data);
      if (never) begin
         chk({nm, " start_cycles"}, k, STO);
         chk({nm, " start_drop"}, uart_start, 0);
      end
      k = 0;
      while (sched_busy && k < 20) begin @(negedge clk); k++; end
      chk({nm, " guard_len"}, k, never ? GUARD + 1 : GUARD);
   endtask

   typedef struct {
      logic [3:0] mask;
      logic [8:0] data;
      int         idx;
      bit         err;
      int         len;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int k, since, pk, mptr, cur, wait_c;
      bit inflt, e_err, e_to, idle;
      logic [8:0] cur_data;
      logic [3:0] exp_g, last_g;

      tbl[0] = '{4'b0100, 9'h1A5, 2, 1'b0, 100};
      tbl[1] = '{4'b1111, 9'h0F0, 3, 1'b0, 4};
      tbl[2] = '{4'b1111, 9'h033, 0, 1'b0, 4};
      tbl[3] = '{4'b0001, 9'h1FF, 0, 1'b0, 3};
      tbl[4] = '{4'b1001, 9'h155, 3, 1'b1, 5};
      tbl[5] = '{4'b0110, 9'h0AA, 1, 1'b0, 2};
      tbl[6] = '{4'b0011, 9'h100, 0, 1'b0, 1};
      tbl[7] = '{4'b1110, 9'h001, 1, 1'b1, 6};

      // Reset state with requests pending and driver ready
      repeat (3) @(negedge clk);
      chk("rst gnt", gnt, 0);
      chk("rst start", uart_start, 0);
      chk("rst data", uart_data, 0);
      chk("rst done", frame_done, 0);
      chk("rst src", frame_src, 0);
      chk("rst err", frame_err, 0);
      chk("rst timeout", frame_timeout, 0);
      chk("rst busy", sched_busy, 0);
      @(posedge clk); #1;
      req = '0; rst_n = 1'b1;

      for (int v = 0; v < 8; v++)
         run_frame($sformatf("vec%0d", v), tbl[v].mask, tbl[v].data, tbl[v].idx, 2,
                   tbl[v].len, tbl[v].err, 1'b0);

      // Fairness: all four requesting continuously
      do_reset();
      drv_lat = 1; drv_len = 3; drv_err = 0; drv_never = 0;
      @(posedge clk); #1 req = 4'b1111;
      for (int f = 0; f < 8; f++) begin
         k = 0;
         do begin @(negedge clk); k++; end while (gnt == '0 && k < 100);
         chk($sformatf("fair%0d", f), gnt, 1 << (f % NR));
      end
      @(posedge clk); #1 req = '0;
      wait_idle("fair");

      run_frame("start_to", 4'b0001, 9'h0C3, 0, 2, 5, 1'b0, 1'b1);
      run_frame("after_to", 4'b0011, 9'h07E, 1, 1, 3, 1'b0, 1'b0);

      // Ready gating, then a request raised while the frame is in WAIT_DONE
      drv_lat = 1; drv_len = 6; drv_err = 0; drv_never = 0;
      @(posedge clk); #1;
      ready_en = 1'b0; req = 4'b0001; req_data[8:0] = 9'h111;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); chk("ready_gate", gnt, 0);
      end
      @(posedge clk); #1 ready_en = 1'b1;
      @(negedge clk); chk("ready_rise gnt", gnt, 4'b0001);
      @(posedge clk); #1 req = '0;
      k = 0;
      do begin @(negedge clk); k++; end while (!uart_busy && k < 50);
      @(posedge clk); #1;
      req = 4'b0010; req_data[17:9] = 9'h0B2;
      k = 0; since = -1;
      do begin
         @(negedge clk); k++;
         if (frame_done) since = 0;
         else if (since >= 0) since++;
      end while (gnt == '0 && k < 100);
      chk("late_req gnt", gnt, 4'b0010);
      chk("late_req spacing", since, GUARD);
      @(posedge clk); #1 req = '0;
      @(negedge clk); chk("late_req data", uart_data, 9'h0B2);
      wait_idle("late_req");

      // Reset in the middle of a frame
      drv_lat = 1; drv_len = 20;
      @(posedge clk); #1 req = 4'b0001;
      k = 0;
      do begin @(negedge clk); k++; end while (gnt == '0 && k < 100);
      @(posedge clk); #1 req = '0;
      k = 0;
      do begin @(negedge clk); k++; end while (!uart_busy && k < 50);
      @(posedge clk); #1;
      @(negedge clk); chk("midrst pre busy", sched_busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst start", uart_start, 0);
      chk("midrst gnt", gnt, 0);
      chk("midrst done", frame_done, 0);
      chk("midrst busy", sched_busy, 0);
      chk("midrst data", uart_data, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      run_frame("post_rst", 4'b1001, 9'h0DD, 0, 1, 3, 1'b0, 1'b0);

      // Randomized traffic against the scoreboard
      do_reset();
      mptr = 0; inflt = 0; wait_c = 0; cur = 0; cur_data = '0; e_err = 0; e_to = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (wait_c > 0) wait_c--;
         if (frame_done) begin
            chk("rnd done_expected", inflt, 1);
            chk("rnd src", frame_src, cur);
            chk("rnd err", frame_err, e_err);
            chk("rnd timeout", frame_timeout, e_to);
            inflt  = 0;
            wait_c = e_to ? GUARD + 1 : GUARD;
            mptr   = (cur + 1) % NR;
         end
         idle = !inflt && (wait_c == 0);
         chk("rnd sched_busy", sched_busy, !idle);
         exp_g = '0;
         pk = -1;
         if (idle && uart_ready && req != '0) begin
            pk = rr_pick(req, mptr);
            exp_g = 4'(1 << pk);
         end
         chk("rnd gnt", gnt, exp_g);
         if (inflt) chk("rnd data", uart_data, cur_data);
         if (pk >= 0) begin
            cur = pk; cur_data = req_data[pk*9 +: 9]; inflt = 1;
            e_to  = ($urandom % 8 == 0);
            e_err = !e_to && ($urandom % 3 == 0);
            drv_never = e_to; drv_err = e_err;
            drv_lat = $urandom_range(1, 4); drv_len = $urandom_range(1, 8);
         end
         last_g = gnt;
         @(posedge clk); #1;
         for (int i = 0; i < NR; i++) begin
            if (req[i] && last_g[i]) begin
               req[i] = ($urandom % 4 == 0);
               req_data[i*9 +: 9] = 9'($urandom);
            end else if (!req[i] && ($urandom % 6 == 0)) begin
               req[i] = 1'b1;
               req_data[i*9 +: 9] = 9'($urandom);
            end
         end
         ready_en = ($urandom % 8 != 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
